// File: rtl/stepper_pkg.sv
// Shared definitions for the cycle stepper: FSM state encoding and the
// default widths of the step-count request and the total-cycles counter.
package stepper_pkg;

  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned TOT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/step_counter.sv
// Loadable down-counter holding the number of datapath steps still to be
// enabled in a counted run. Decrements stop at zero so the count can never
// wrap into a huge value.
module step_counter
  import stepper_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: a load wins over a decrement; decrement only while non-zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != CNT_ZERO)) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == CNT_ZERO);

endmodule

// File: rtl/cycle_stepper.sv
// Cycle stepper: gates a datapath clock-enable for either a counted number
// of steps or a free run that ends on stop/halt_in. Every output is a flop
// whose next value is derived from the next FSM state, so cpu_en has no
// combinational path from any input.
module cycle_stepper
  import stepper_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned TOT_W = TOT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] steps,
  input  logic             stop,
  input  logic             halt_in,
  output logic             cpu_en,
  output logic             busy,
  output logic             done,
  output logic [TOT_W-1:0] cycles_run
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TOT_W-1:0] TOT_ZERO = {TOT_W{1'b0}};
  localparam logic [TOT_W-1:0] TOT_ONE  = {{(TOT_W-1){1'b0}}, 1'b1};

  state_e           state_d;
  state_e           state_q;
  logic             mode_d;
  logic             mode_q;
  logic             cpu_en_d;
  logic             cpu_en_q;
  logic             busy_d;
  logic             busy_q;
  logic             done_d;
  logic             done_q;
  logic [TOT_W-1:0] cycles_d;
  logic [TOT_W-1:0] cycles_q;

  logic             cnt_load_s;
  logic             cnt_dec_s;
  logic [CNT_W-1:0] cnt_s;
  logic             cnt_zero_s;
  logic             last_step_s;

  // A run is accepted only from IDLE; the counter is only consumed in counted RUN.
  assign cnt_load_s = (state_q == IDLE) && start;
  assign cnt_dec_s  = (state_q == RUN) && !mode_q;

  // Final counted step: one remaining. A zero count in RUN also ends the run
  // so a corrupted counter can never turn a counted run into an endless one.
  assign last_step_s = (cnt_s == CNT_ONE) || cnt_zero_s;

  step_counter #(
    .CNT_W (CNT_W)
  ) u_step_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load_s),
    .load_val_i (steps),
    .dec_i      (cnt_dec_s),
    .cnt_o      (cnt_s),
    .zero_o     (cnt_zero_s)
  );

  // Next-state logic; registered outputs follow the next state.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = mode;
          if (mode || (steps != CNT_ZERO)) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (stop || halt_in || (!mode_q && last_step_s)) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    cpu_en_d = (state_d == RUN);
    busy_d   = (state_d == RUN);
    done_d   = (state_d == DONE);
  end

  // Total enabled-cycle counter, holding at all-ones once saturated.
  always_comb begin
    cycles_d = cycles_q;
    if (cpu_en_q && (cycles_q != {TOT_W{1'b1}})) begin
      cycles_d = cycles_q + TOT_ONE;
    end else begin
      cycles_d = cycles_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      cpu_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cycles_q <= TOT_ZERO;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cpu_en_q <= cpu_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cycles_q <= cycles_d;
    end
  end

  assign cpu_en     = cpu_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cycles_run = cycles_q;

endmodule

// File: tb/tb_cycle_stepper.sv
// Directed bench for cycle_stepper. A default-width instance covers the
// functional scenarios; a TOT_W=4 instance sharing the same stimulus covers
// saturation of the total-cycles counter.
module tb_cycle_stepper;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic [7:0] steps;
  logic       stop;
  logic       halt_in;

  logic        cpu_en;
  logic        busy;
  logic        done;
  logic [15:0] cycles_run;

  logic        cpu_en4;
  logic        busy4;
  logic        done4;
  logic [3:0]  cycles_run4;

  int n_checks;
  int n_fail;

  cycle_stepper #(.CNT_W(8), .TOT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .steps      (steps),
    .stop       (stop),
    .halt_in    (halt_in),
    .cpu_en     (cpu_en),
    .busy       (busy),
    .done       (done),
    .cycles_run (cycles_run)
  );

  cycle_stepper #(.CNT_W(8), .TOT_W(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .steps      (steps),
    .stop       (stop),
    .halt_in    (halt_in),
    .cpu_en     (cpu_en4),
    .busy       (busy4),
    .done       (done4),
    .cycles_run (cycles_run4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1ns so registered outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e_en, input logic e_busy,
                            input logic e_done, input int e_cyc);
    check_eq({tag, "_cpu_en"}, {31'd0, cpu_en}, {31'd0, e_en});
    check_eq({tag, "_busy"},   {31'd0, busy},   {31'd0, e_busy});
    check_eq({tag, "_done"},   {31'd0, done},   {31'd0, e_done});
    check_eq({tag, "_cycles"}, {16'd0, cycles_run}, e_cyc);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    mode     = 1'b0;
    steps    = 8'd0;
    stop     = 1'b0;
    halt_in  = 1'b0;

    // Reset, including a start pulse coincident with reset
    step();
    step();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 0);
    start = 1'b1; mode = 1'b1;
    step();
    check_outs("start_in_reset", 1'b0, 1'b0, 1'b0, 0);
    start = 1'b0; rst_n = 1'b1;
    step();
    check_outs("after_reset", 1'b0, 1'b0, 1'b0, 0);

    // Counted run of 5 steps
    start = 1'b1; mode = 1'b0; steps = 8'd5;
    step();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      check_outs($sformatf("cnt5_c%0d", i), 1'b1, 1'b1, 1'b0, i - 1);
      step();
    end
    check_outs("cnt5_done", 1'b0, 1'b0, 1'b1, 5);
    step();
    check_outs("cnt5_idle", 1'b0, 1'b0, 1'b0, 5);

    // Zero-step request: straight to DONE
    start = 1'b1; mode = 1'b0; steps = 8'd0;
    step();
    start = 1'b0;
    check_outs("zero_done", 1'b0, 1'b0, 1'b1, 5);
    step();
    check_outs("zero_idle", 1'b0, 1'b0, 1'b0, 5);

    // stop/halt_in in IDLE are ignored
    stop = 1'b1; halt_in = 1'b1;
    step();
    stop = 1'b0; halt_in = 1'b0;
    check_outs("idle_stop", 1'b0, 1'b0, 1'b0, 5);

    // Free run, stop in the 3rd enabled cycle
    start = 1'b1; mode = 1'b1; steps = 8'd0;
    step();
    start = 1'b0;
    check_outs("free_c1", 1'b1, 1'b1, 1'b0, 5);
    step();
    check_outs("free_c2", 1'b1, 1'b1, 1'b0, 6);
    step();
    check_outs("free_c3", 1'b1, 1'b1, 1'b0, 7);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_outs("free_done", 1'b0, 1'b0, 1'b1, 8);
    step();
    check_outs("free_idle", 1'b0, 1'b0, 1'b0, 8);

    // steps=4, start re-pulsed in RUN, halt_in in 2nd cycle, start in DONE
    start = 1'b1; mode = 1'b0; steps = 8'd4;
    step();
    check_outs("halt_c1", 1'b1, 1'b1, 1'b0, 8);
    start = 1'b1;
    step();
    start = 1'b0;
    check_outs("halt_c2", 1'b1, 1'b1, 1'b0, 9);
    halt_in = 1'b1;
    step();
    halt_in = 1'b0;
    check_outs("halt_done", 1'b0, 1'b0, 1'b1, 10);
    start = 1'b1;
    step();
    start = 1'b0;
    check_outs("halt_idle", 1'b0, 1'b0, 1'b0, 10);
    step();
    check_outs("halt_noqueue", 1'b0, 1'b0, 1'b0, 10);

    // Last counted step together with stop and halt_in: a single DONE
    start = 1'b1; mode = 1'b0; steps = 8'd3;
    step();
    start = 1'b0;
    check_outs("coinc_c1", 1'b1, 1'b1, 1'b0, 10);
    step();
    check_outs("coinc_c2", 1'b1, 1'b1, 1'b0, 11);
    step();
    check_outs("coinc_c3", 1'b1, 1'b1, 1'b0, 12);
    stop = 1'b1; halt_in = 1'b1;
    step();
    check_outs("coinc_done", 1'b0, 1'b0, 1'b1, 13);
    step();
    stop = 1'b0; halt_in = 1'b0;
    check_outs("coinc_idle", 1'b0, 1'b0, 1'b0, 13);

    // Reset in the 4th enabled cycle of a 10-step run
    start = 1'b1; mode = 1'b0; steps = 8'd10;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check_outs("rstrun_c4", 1'b1, 1'b1, 1'b0, 16);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_outs("rstrun_abort", 1'b0, 1'b0, 1'b0, 0);
    check_eq("rstrun_cycles4", {28'd0, cycles_run4}, 32'd0);
    step();
    check_outs("rstrun_nodone", 1'b0, 1'b0, 1'b0, 0);

    // Free run of 20 enabled cycles: 4-bit counter saturates at 15
    start = 1'b1; mode = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 20; i++) begin
      step();
    end
    check_eq("sat_c20_cpu_en4", {31'd0, cpu_en4}, 32'd1);
    check_eq("sat_c20_cycles4", {28'd0, cycles_run4}, 32'd15);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_eq("sat_done4", {31'd0, done4}, 32'd1);
    check_eq("sat_cycles4", {28'd0, cycles_run4}, 32'd15);
    check_outs("sat_wide", 1'b0, 1'b0, 1'b1, 20);
    step();
    check_eq("sat_idle4", {31'd0, busy4}, 32'd0);
    check_eq("sat_hold4", {28'd0, cycles_run4}, 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
